// File: rtl/pwm_pkg.sv
// Shared constants for the single-channel PWM generator.
//   CNT_W_DEF  : default counter / CYCLE / DUTY width (matches the 28-bit PIO out_port)
//   DEAD_W_DEF : default dead-time counter width
//   ST_*       : controller state encodings
package pwm_pkg;

  localparam int unsigned CNT_W_DEF  = 28;
  localparam int unsigned DEAD_W_DEF = 8;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd2;

endpackage : pwm_pkg

// File: rtl/pwm_deadband.sv
// Dead-time insertion for a complementary PWM pair.
// Each output rises dead_in ticks after the raw edge that enables it and
// drops at once on the opposite raw edge, so pwm_hi and pwm_lo never overlap.
// A raw phase shorter than dead_in never lets its output rise.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   active       : generator running; when low both outputs are held low
//   raw          : undelayed PWM level
//   dead_in      : dead-time in ticks
//   pwm_hi       : delayed high-side output (registered)
//   pwm_lo       : delayed low-side output (registered)
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              active,
  input  logic              raw,
  input  logic [DEAD_W-1:0] dead_in,
  output logic              pwm_hi,
  output logic              pwm_lo
);

  logic              raw_q;
  logic [DEAD_W-1:0] tmr;
  logic [DEAD_W-1:0] rem_c;

  // Remaining dead ticks for this tick: reload on any raw edge.
  always_comb begin
    rem_c = tmr;
    if (raw != raw_q) rem_c = dead_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q  <= 1'b0;
      tmr    <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else if (!active) begin
      raw_q  <= 1'b0;
      tmr    <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      raw_q  <= raw;
      tmr    <= (rem_c == '0) ? '0 : rem_c - DEAD_W'(1);
      pwm_hi <= raw && (rem_c == '0);
      pwm_lo <= !raw && (rem_c == '0);
    end
  end

endmodule : pwm_deadband

// File: rtl/pwm_period_gen.sv
// Single-channel PWM generator with double-buffered CYCLE/DUTY registers.
// New CYCLE/DUTY values are taken only at a period boundary (glitch-free).
// Optional feature macro: PWM_DEADTIME_EN adds dead_in / pwm_n_out and a
// dead-time stage on the complementary pair.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : run request (level)
//   cycle_in      : period in clk ticks
//   duty_in       : high time in clk ticks
//   dead_in       : dead-time in ticks (PWM_DEADTIME_EN only)
//   pwm_out       : PWM output, one cycle behind cnt_out
//   pwm_n_out     : complementary output (PWM_DEADTIME_EN only)
//   period_strobe : high while cnt_out is on the last tick of a period
//   cnt_out       : current period counter
module pwm_period_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef PWM_DEADTIME_EN
  ,
  parameter int unsigned DEAD_W = DEAD_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] cycle_in,
  input  logic [CNT_W-1:0] duty_in,
`ifdef PWM_DEADTIME_EN
  input  logic [DEAD_W-1:0] dead_in,
  output logic              pwm_n_out,
`endif
  output logic             pwm_out,
  output logic             period_strobe,
  output logic [CNT_W-1:0] cnt_out
);

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cyc_sh, cyc_nxt;
  logic [CNT_W-1:0] duty_sh, duty_nxt;
  logic             strobe_nxt;
  logic             active_c;
  logic             raw_c;

  // Next-state, counter and shadow-register logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cyc_nxt   = cyc_sh;
    duty_nxt  = duty_sh;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        cyc_nxt   = cycle_in;
        duty_nxt  = duty_in;
        cnt_nxt   = '0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if ((cyc_sh == '0) || (cnt == cyc_sh - CNT_W'(1))) begin
          // Zero period reloads every cycle so a new CYCLE starts promptly.
          cnt_nxt  = '0;
          cyc_nxt  = cycle_in;
          duty_nxt = duty_in;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Strobe is registered but lined up with the last tick of the period.
    strobe_nxt = (state_nxt == ST_RUN) && (cyc_nxt != '0) &&
                 (cnt_nxt == cyc_nxt - CNT_W'(1));
  end

  // Raw PWM level for the current tick; dropped at once when enable falls.
  assign active_c = (state == ST_RUN) && enable && (cyc_sh != '0);
  assign raw_c    = active_c && (cnt < duty_sh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cyc_sh        <= '0;
      duty_sh       <= '0;
      period_strobe <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      cyc_sh        <= cyc_nxt;
      duty_sh       <= duty_nxt;
      period_strobe <= strobe_nxt;
    end
  end

  assign cnt_out = cnt;

`ifdef PWM_DEADTIME_EN
  pwm_deadband #(
    .DEAD_W (DEAD_W)
  ) u_deadband (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (active_c),
    .raw     (raw_c),
    .dead_in (dead_in),
    .pwm_hi  (pwm_out),
    .pwm_lo  (pwm_n_out)
  );
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_out <= 1'b0;
    else          pwm_out <= raw_c;
  end
`endif

endmodule : pwm_period_gen

// File: tb/tb_pwm_period_gen.sv
// Bench for pwm_period_gen: cycle table for start-up and a mid-period DUTY
// write, followed by directed sequences for the boundary cases.
module tb_pwm_period_gen;

  localparam int unsigned CW = 28;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [CW-1:0] cycle_in;
  logic [CW-1:0] duty_in;
  logic          pwm_out;
  logic          period_strobe;
  logic [CW-1:0] cnt_out;
`ifdef PWM_DEADTIME_EN
  logic [7:0]    dead_in;
  logic          pwm_n_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pwm_period_gen #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .cycle_in      (cycle_in),
    .duty_in       (duty_in),
`ifdef PWM_DEADTIME_EN
    .dead_in       (dead_in),
    .pwm_n_out     (pwm_n_out),
`endif
    .pwm_out       (pwm_out),
    .period_strobe (period_strobe),
    .cnt_out       (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [CW-1:0] cyc;
    logic [CW-1:0] duty;
    logic [CW-1:0] exp_cnt;
    logic          exp_pwm;
    logic          exp_stb;
  } vec_t;

  vec_t vecs[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Step until a strobe is seen, bounded.
  task automatic sync_period(input string name);
    int k = 0;
    do begin
      step();
      k++;
    end while (!period_strobe && k < 40);
    chk(name, 32'(period_strobe), 32'd1);
  endtask

  // Count pwm highs and strobes over n cycles.
  task automatic measure(input int n, output int highs, output int strobes);
    highs = 0;
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      step();
      highs   += int'(pwm_out);
      strobes += int'(period_strobe);
    end
  endtask

  initial begin
    int hi, st, k;

    // cycle=10, duty=3 start-up, then duty 3->7 written while cnt=4
    vecs[0]  = '{1'b0, 10, 3, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 10, 3, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10, 3, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10, 3, 1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 10, 3, 2, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 10, 3, 3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 10, 3, 4, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 10, 3, 5, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 10, 3, 6, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 10, 3, 7, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 10, 3, 8, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 10, 3, 9, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 10, 3, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 10, 3, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 10, 3, 2, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 10, 3, 3, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 10, 3, 4, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 10, 7, 5, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 10, 7, 6, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 10, 7, 7, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 10, 7, 8, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 10, 7, 9, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 10, 7, 0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 10, 7, 1, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 10, 7, 2, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 10, 7, 3, 1'b1, 1'b0};
    vecs[26] = '{1'b1, 10, 7, 4, 1'b1, 1'b0};
    vecs[27] = '{1'b1, 10, 7, 5, 1'b1, 1'b0};
    vecs[28] = '{1'b1, 10, 7, 6, 1'b1, 1'b0};
    vecs[29] = '{1'b1, 10, 7, 7, 1'b1, 1'b0};
    vecs[30] = '{1'b1, 10, 7, 8, 1'b0, 1'b0};
    vecs[31] = '{1'b1, 10, 7, 9, 1'b0, 1'b1};

    reset_n  = 1'b0;
    enable   = 1'b0;
    cycle_in = '0;
    duty_in  = '0;
`ifdef PWM_DEADTIME_EN
    dead_in  = '0;
`endif
    repeat (2) step();
    chk("reset_cnt", 32'(cnt_out), 32'd0);
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_stb", 32'(period_strobe), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      enable   = vecs[i].en;
      cycle_in = vecs[i].cyc;
      duty_in  = vecs[i].duty;
      step();
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_out), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_pwm", i), 32'(pwm_out), 32'(vecs[i].exp_pwm));
      chk($sformatf("vec%0d_stb", i), 32'(period_strobe), 32'(vecs[i].exp_stb));
    end

    // duty=0: never high; strobe still once per period
    duty_in = 0;
    sync_period("duty0_sync");
    step();
    measure(10, hi, st);
    chk("duty0_highs", 32'(hi), 32'd0);
    chk("duty0_strobes", 32'(st), 32'd1);

    // duty=12 > cycle=10: constantly high
    duty_in = 12;
    sync_period("duty12_sync");
    step();
    measure(10, hi, st);
    chk("duty12_highs", 32'(hi), 32'd10);
    chk("duty12_strobes", 32'(st), 32'd1);

    // cycle=0: counter parked, output low, no strobe
    cycle_in = 0;
    sync_period("cyc0_sync");
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("cyc0_cnt%0d", i), 32'(cnt_out), 32'd0);
      chk($sformatf("cyc0_pwm%0d", i), 32'(pwm_out), 32'd0);
      chk($sformatf("cyc0_stb%0d", i), 32'(period_strobe), 32'd0);
    end

    // cycle=5, duty=2 written while parked: counting starts next cycle
    cycle_in = 5;
    duty_in  = 2;
    step();
    chk("cyc5_w_cnt", 32'(cnt_out), 32'd0);
    chk("cyc5_w_stb", 32'(period_strobe), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("cyc5_cnt%0d", i), 32'(cnt_out), 32'(i));
      chk($sformatf("cyc5_pwm%0d", i), 32'(pwm_out), (i <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("cyc5_stb%0d", i), 32'(period_strobe), (i == 4) ? 32'd1 : 32'd0);
    end

    // Drop enable at cnt=6
    cycle_in = 10;
    duty_in  = 10;
    sync_period("abort_sync");
    k = 0;
    do begin
      step();
      k++;
    end while (cnt_out != 6 && k < 30);
    chk("abort_reach6", 32'(cnt_out), 32'd6);
    chk("abort_pwm_before", 32'(pwm_out), 32'd1);
    enable = 1'b0;
    step();
    chk("abort_cnt", 32'(cnt_out), 32'd0);
    chk("abort_pwm", 32'(pwm_out), 32'd0);
    chk("abort_stb", 32'(period_strobe), 32'd0);
    step();
    chk("idle_cnt", 32'(cnt_out), 32'd0);
    chk("idle_pwm", 32'(pwm_out), 32'd0);

    // Asynchronous reset mid-RUN
    enable = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (cnt_out != 5 && k < 30);
    chk("arst_reach5", 32'(cnt_out), 32'd5);
    chk("arst_pwm_before", 32'(pwm_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt_out), 32'd0);
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_stb", 32'(period_strobe), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_arst_cnt", 32'(cnt_out), 32'd0);

`ifdef PWM_DEADTIME_EN
    // cycle=20, duty=10, dead=2: hi on ticks 2..9, lo on ticks 12..19
    cycle_in = 20;
    duty_in  = 10;
    dead_in  = 2;
    sync_period("dt_sync1");
    sync_period("dt_sync2");
    step();
    for (int j = 1; j <= 20; j++) begin
      step();
      chk($sformatf("dt_hi%0d", j - 1), 32'(pwm_out),
          ((j - 1) >= 2 && (j - 1) <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("dt_lo%0d", j - 1), 32'(pwm_n_out),
          ((j - 1) >= 12) ? 32'd1 : 32'd0);
      chk($sformatf("dt_both%0d", j - 1), 32'(pwm_out & pwm_n_out), 32'd0);
    end

    // dead=12 exceeds the 10-tick high phase: high side never rises
    dead_in = 12;
    sync_period("dt12_sync");
    step();
    measure(20, hi, st);
    chk("dt12_highs", 32'(hi), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_period_gen
